// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if
//   Groups the request/grant/data signals of the round-robin mux arbiter.
//   Signals:
//     req[3:0]      level request per requester
//     done[3:0]     release strobe per requester (owner's bit only counts)
//     data_in[3:0]  data bit per requester, routed through the mux
//     gnt[3:0]      one-hot grant
//     sel[1:0]      mux select (encoded owner)
//     valid         grant active
//     data_out      muxed data bit, forced to 0 when no grant
//     timeout       one-cycle pulse on forced release
//   Modports: master = requester side, slave = arbiter side.
interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] data_in;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       data_out;
    logic       timeout;

    modport master (
        output req, done, data_in,
        input  gnt, sel, valid, data_out, timeout
    );

    modport slave (
        input  req, done, data_in,
        output gnt, sel, valid, data_out, timeout
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// four_bit_mux
//   4:1 single-bit multiplexer used as the arbiter datapath.
//   Ports: in0..in3 data inputs, sel 2-bit select, out selected bit.
module four_bit_mux (
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic [1:0] sel,
    output logic       out
);
    always_comb begin
        out = in0;
        case (sel)
            2'd0: out = in0;
            2'd1: out = in1;
            2'd2: out = in2;
            2'd3: out = in3;
            default: out = in0;
        endcase
    end
endmodule

// mux_rr_arbiter
//   Round-robin arbiter sharing the four_bit_mux output among four
//   requesters. One owner at a time, forced release after MAX_HOLD grant
//   cycles (0 = unlimited), and a one-cycle gap between owners.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mux_rr_arbiter_if.slave (req/done/data_in in; gnt/sel/valid/
//            data_out/timeout out)
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_rr_arbiter_if.slave     bus
);
    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]    r_state;
    logic [3:0]    r_gnt;
    logic [1:0]    r_sel;
    logic          r_valid;
    logic          r_timeout;
    logic [CW-1:0] r_count;
    logic [1:0]    r_ptr;

    logic [1:0]    w_winner;
    logic [1:0]    w_idx;
    logic          w_found;
    logic          w_any_req;
    logic          w_own_req;
    logic          w_own_done;
    logic          w_at_limit;
    logic          w_release;
    logic          w_mux_out;

    // Scan ptr+1, ptr+2, ptr+3, ptr so the last owner has lowest priority.
    always_comb begin
        w_winner = r_ptr;
        w_idx    = r_ptr;
        w_found  = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_idx = r_ptr + k[1:0];
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_any_req  = |bus.req;
    // r_sel equals the owner while in GRANT.
    assign w_own_req  = bus.req[r_sel];
    assign w_own_done = bus.done[r_sel];
    assign w_at_limit = (MAX_HOLD != 0) && (r_count == HOLD_LIM);
    assign w_release  = w_own_done | ~w_own_req | w_at_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_sel     <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_count   <= '0;
            r_ptr     <= 2'd3;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_GRANT: begin
                    if (w_release) begin
                        r_gnt     <= '0;
                        r_valid   <= 1'b0;
                        r_state   <= ST_GAP;
                        // Timeout only when the hold limit is the sole cause.
                        r_timeout <= w_at_limit & ~w_own_done & w_own_req;
                    end else if (MAX_HOLD != 0) begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: begin
                    // IDLE and GAP arbitrate identically; sel is left alone
                    // when nobody requests so the mux does not glitch.
                    if (w_any_req) begin
                        r_gnt   <= 4'b0001 << w_winner;
                        r_sel   <= w_winner;
                        r_valid <= 1'b1;
                        r_count <= CW'(1);
                        r_ptr   <= w_winner;
                        r_state <= ST_GRANT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    four_bit_mux u_mux (
        .in0 (bus.data_in[0]),
        .in1 (bus.data_in[1]),
        .in2 (bus.data_in[2]),
        .in3 (bus.data_in[3]),
        .sel (r_sel),
        .out (w_mux_out)
    );

    assign bus.gnt      = r_gnt;
    assign bus.sel      = r_sel;
    assign bus.valid    = r_valid;
    assign bus.timeout  = r_timeout;
    assign bus.data_out = r_valid & w_mux_out;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Directed bench for mux_rr_arbiter (MAX_HOLD=8): table-driven vectors
//   for single-requester and fairness/withdraw behaviour, plus hand-written
//   sequences for hold-limit timeout, done/limit coincidence and
//   asynchronous reset mid-grant.
module tb_mux_rr_arbiter;
    logic clk;
    logic rst_n;

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] din;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       dout;
        logic       tmo;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_err;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] eg, input logic [1:0] es,
                         input logic ev, input logic ed, input logic et);
        n_vec++;
        if ({bus.gnt, bus.sel, bus.valid, bus.data_out, bus.timeout} !== {eg, es, ev, ed, et}) begin
            n_err++;
            $display("FAIL %s: got gnt=%b sel=%0d valid=%b dout=%b tmo=%b, want gnt=%b sel=%0d valid=%b dout=%b tmo=%b",
                     nm, bus.gnt, bus.sel, bus.valid, bus.data_out, bus.timeout, eg, es, ev, ed, et);
        end
    endtask

    task automatic add(input logic [3:0] req, input logic [3:0] done, input logic [3:0] din,
                       input logic [3:0] gnt, input logic [1:0] sel, input logic valid,
                       input logic dout, input logic tmo);
        vec_t v;
        v.req = req; v.done = done; v.din = din;
        v.gnt = gnt; v.sel = sel; v.valid = valid; v.dout = dout; v.tmo = tmo;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            bus.req     = tbl[i].req;
            bus.done    = tbl[i].done;
            bus.data_in = tbl[i].din;
            step();
            check($sformatf("%s[%0d]", nm, i), tbl[i].gnt, tbl[i].sel,
                  tbl[i].valid, tbl[i].dout, tbl[i].tmo);
        end
        tbl.delete();
    endtask

    // Called just after an edge, so the pulse sits well between edges.
    task automatic do_reset();
        bus.req  = '0;
        bus.done = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req = '0;
        bus.done = '0;
        bus.data_in = '0;

        step();
        check("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Single requester 2: three grant cycles, done in the 3rd, gap, regrant.
        //   req      done     din      gnt      sel v  d  t
        add(4'b0100, 4'b0000, 4'b0100, 4'b0100, 2, 1, 1, 0);
        add(4'b0100, 4'b0000, 4'b0100, 4'b0100, 2, 1, 1, 0);
        add(4'b0100, 4'b0000, 4'b0100, 4'b0100, 2, 1, 1, 0);
        add(4'b0100, 4'b0100, 4'b0100, 4'b0000, 2, 0, 0, 0);
        add(4'b0100, 4'b0000, 4'b0100, 4'b0100, 2, 1, 1, 0);
        add(4'b0000, 4'b0000, 4'b0100, 4'b0000, 2, 0, 0, 0);
        add(4'b0000, 4'b0000, 4'b0100, 4'b0000, 2, 0, 0, 0);
        run_table("single");

        do_reset();

        // Fairness: all request, owner releases after one cycle -> 0,1,2,3,0.
        add(4'b1111, 4'b0000, 4'b0101, 4'b0001, 0, 1, 1, 0);
        add(4'b1111, 4'b0001, 4'b0101, 4'b0000, 0, 0, 0, 0);
        add(4'b1111, 4'b0000, 4'b0101, 4'b0010, 1, 1, 0, 0);
        add(4'b1111, 4'b0010, 4'b0101, 4'b0000, 1, 0, 0, 0);
        add(4'b1111, 4'b0000, 4'b0101, 4'b0100, 2, 1, 1, 0);
        add(4'b1111, 4'b0100, 4'b0101, 4'b0000, 2, 0, 0, 0);
        add(4'b1111, 4'b0000, 4'b0101, 4'b1000, 3, 1, 0, 0);
        add(4'b1111, 4'b1000, 4'b0101, 4'b0000, 3, 0, 0, 0);
        add(4'b1111, 4'b0000, 4'b0101, 4'b0001, 0, 1, 1, 0);
        add(4'b0000, 4'b0000, 4'b0101, 4'b0000, 0, 0, 0, 0);
        add(4'b0000, 4'b0000, 4'b0101, 4'b0000, 0, 0, 0, 0);
        // Withdraw: owner 1 drops req -> gap, idle, sel held at 1.
        add(4'b0010, 4'b0000, 4'b0010, 4'b0010, 1, 1, 1, 0);
        add(4'b0010, 4'b0000, 4'b0010, 4'b0010, 1, 1, 1, 0);
        add(4'b0000, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 0);
        add(4'b0000, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 0);
        add(4'b0000, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 0);
        // Owner 2: non-owner done and non-owner req changes are ignored.
        add(4'b0100, 4'b0000, 4'b0100, 4'b0100, 2, 1, 1, 0);
        add(4'b0100, 4'b1000, 4'b0100, 4'b0100, 2, 1, 1, 0);
        add(4'b0100, 4'b1000, 4'b0000, 4'b0100, 2, 1, 0, 0);
        add(4'b0100, 4'b0000, 4'b0100, 4'b0100, 2, 1, 1, 0);
        add(4'b1101, 4'b0010, 4'b0100, 4'b0100, 2, 1, 1, 0);
        add(4'b0000, 4'b0000, 4'b0100, 4'b0000, 2, 0, 0, 0);
        add(4'b0000, 4'b0000, 4'b0100, 4'b0000, 2, 0, 0, 0);
        run_table("fair");

        // Hold-limit timeout: req 0 and 1, no done.
        do_reset();
        bus.req = 4'b0011;
        bus.data_in = 4'b0011;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("to_own0_c%0d", i), 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        end
        step();
        check("to_gap0", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("to_own1_c%0d", i), 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        end
        step();
        check("to_gap1", 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1);
        step();
        check("co_own0_c1", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);

        // done on the 8th grant cycle coincides with the limit: no timeout.
        for (int i = 2; i <= 8; i++) begin
            step();
            check($sformatf("co_own0_c%0d", i), 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        end
        bus.done = 4'b0001;
        step();
        check("co_gap", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        bus.done = 4'b0000;
        step();
        check("co_own1", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);

        // Async reset while owner 3 holds the grant.
        do_reset();
        bus.req = 4'b1000;
        bus.data_in = 4'b1000;
        step();
        check("ar_own3", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_async", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        bus.req = 4'b1001;
        bus.data_in = 4'b1001;
        #1;
        rst_n = 1'b1;
        step();
        check("ar_own0", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        bus.done = 4'b0001;
        step();
        check("ar_gap0", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        // Previous owner 0 still requests but 3 also does: 3 wins.
        bus.done = 4'b0000;
        step();
        check("ar_own3b", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
        bus.done = 4'b1000;
        step();
        check("ar_gap3", 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);
        bus.done = 4'b0000;
        step();
        check("ar_own0b", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        // Only the previous owner requests: it wins again after the gap.
        bus.req = 4'b0001;
        bus.done = 4'b0001;
        step();
        check("ar_gap0b", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        bus.done = 4'b0000;
        step();
        check("ar_own0c", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
